// File: rtl/uart_tx_param_if.sv
// -----------------------------------------------------------------------------
// uart_tx_param_if
// Word handshake between the system controller TX path and uart_tx_param.
//
// A word moves on a rising clock edge where Data_Valid && Ready are both high.
// The master drives P_DATA and Data_Valid and holds them until that edge.
// Ready comes only from the slave's registers; it never depends on Data_Valid.
//
// Signals:
//   P_DATA     [DATA_WIDTH-1:0]  word to transmit          (master -> slave)
//   Data_Valid                   word offer                (master -> slave)
//   Ready                        slave can take a word now (slave -> master)
// -----------------------------------------------------------------------------
interface uart_tx_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Ready;

    modport master (
        output P_DATA,
        output Data_Valid,
        input  Ready
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        output Ready
    );
endinterface

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter. Each frame is a start bit, then DATA_WIDTH
// data bits (LSB first), then an optional parity bit, then 1 or 2 stop bits.
// Every bit lasts max(i_prescale,1) clocks. The block runs on the UART clock,
// so it needs no external baud tick.
//
// Build option:
//   UART_TX_HOLD_REG_EN  adds a one-entry holding register. A word may be
//                        accepted during a frame and is sent right after the
//                        current stop bits. Ready = holding register empty.
//   (undefined)          Ready = idle || last stop clock.
//
// Ports:
//   clk, rst        transmit clock; asynchronous active-high reset
//   bus             slave side of uart_tx_param_if (P_DATA/Data_Valid/Ready)
//   i_par_en        1: insert a parity bit
//   i_par_typ       0: even parity, 1: odd parity
//   i_stop_two      1: two stop bits, 0: one stop bit
//   i_prescale      clocks per bit; 0 is treated as 1
//   o_tx_out        serial line, idle high, registered
//   o_busy          high while a frame is on the line
//   o_frame_done    one-cycle pulse on the last clock of the final stop bit
//   o_state         debug view of the FSM state
// -----------------------------------------------------------------------------
module uart_tx_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    uart_tx_param_if.slave            bus,
    input  logic                      i_par_en,
    input  logic                      i_par_typ,
    input  logic                      i_stop_two,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_tx_out,
    output logic                      o_busy,
    output logic                      o_frame_done,
    output logic [2:0]                o_state
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] P_ONE    = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                    r_state;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [PRESCALE_WIDTH-1:0] r_p;
    logic [IDX_W-1:0]          r_bit_idx;
    logic                      r_stop_idx;
    logic                      r_par_en;
    logic                      r_stop_two;
    logic                      r_parity;
    logic                      r_tx;
    logic                      r_busy;
    logic                      r_frame_done;

    logic                      w_ready;
    logic                      w_accept;
    logic                      w_hold_valid;
    logic [DATA_WIDTH-1:0]     w_hold_data;
    logic                      w_start_frame;
    logic [DATA_WIDTH-1:0]     w_next_word;
    logic [PRESCALE_WIDTH-1:0] w_p_new;
    logic [PRESCALE_WIDTH-1:0] w_p_last;
    logic [PRESCALE_WIDTH-1:0] w_cnt_inc;
    logic                      w_last_clk;
    logic                      w_p_is_one;
    logic                      w_final_stop;

    assign w_accept     = bus.Data_Valid && w_ready;
    assign w_p_new      = (i_prescale == '0) ? P_ONE : i_prescale;
    assign w_p_last     = r_p - P_ONE;
    assign w_cnt_inc    = r_cnt + P_ONE;
    assign w_last_clk   = (r_cnt == w_p_last);
    assign w_p_is_one   = (r_p == P_ONE);
    // True while the current stop bit is the last one of the frame.
    assign w_final_stop = r_stop_idx || !r_stop_two;

    // r_frame_done is high exactly on the last stop clock, so it doubles as
    // the frame-end marker. The holding register is empty whenever the FSM
    // is idle, so this one condition covers both build variants.
    assign w_start_frame = ((r_state == ST_IDLE) || r_frame_done) &&
                           (w_hold_valid || w_accept);
    assign w_next_word   = w_hold_valid ? w_hold_data : bus.P_DATA;

`ifdef UART_TX_HOLD_REG_EN
    logic                  r_hold_valid;
    logic [DATA_WIDTH-1:0] r_hold_data;

    // A word accepted while a frame is running parks here. A word accepted
    // when the line is free (idle or last stop clock) goes straight into the
    // shift register instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (w_start_frame) begin
            r_hold_valid <= 1'b0;
        end else if (w_accept) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= bus.P_DATA;
        end
    end

    assign w_hold_valid = r_hold_valid;
    assign w_hold_data  = r_hold_data;
    assign w_ready      = !r_hold_valid;
`else
    assign w_hold_valid = 1'b0;
    assign w_hold_data  = '0;
    assign w_ready      = (r_state == ST_IDLE) || r_frame_done;
`endif

    // All outputs are registered. Each branch sets them for the state being
    // entered. r_frame_done is raised one edge ahead so that it is high
    // during the last clock of the final stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_p          <= P_ONE;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_par_en     <= 1'b0;
            r_stop_two   <= 1'b0;
            r_parity     <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_start_frame) begin
                // Latch the word and the whole frame config here; later
                // changes on the config inputs wait for the next frame.
                r_state    <= ST_START;
                r_shift    <= w_next_word;
                r_par_en   <= i_par_en;
                r_stop_two <= i_stop_two;
                r_p        <= w_p_new;
                r_parity   <= (^w_next_word) ^ i_par_typ;
                r_cnt      <= '0;
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
                r_tx       <= 1'b0;
                r_busy     <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    ST_START: begin
                        if (w_last_clk) begin
                            r_state <= ST_DATA;
                            r_cnt   <= '0;
                            r_tx    <= r_shift[0];
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_DATA: begin
                        if (w_last_clk) begin
                            r_cnt   <= '0;
                            r_shift <= r_shift >> 1;
                            if (r_bit_idx == LAST_IDX) begin
                                if (r_par_en) begin
                                    r_state <= ST_PARITY;
                                    r_tx    <= r_parity;
                                end else begin
                                    r_state      <= ST_STOP;
                                    r_stop_idx   <= 1'b0;
                                    r_tx         <= 1'b1;
                                    r_frame_done <= w_p_is_one && !r_stop_two;
                                end
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                                r_tx      <= r_shift[1];
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_PARITY: begin
                        if (w_last_clk) begin
                            r_state      <= ST_STOP;
                            r_cnt        <= '0;
                            r_stop_idx   <= 1'b0;
                            r_tx         <= 1'b1;
                            r_frame_done <= w_p_is_one && !r_stop_two;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_STOP: begin
                        if (w_last_clk) begin
                            if (!w_final_stop) begin
                                // First of two stop bits done.
                                r_stop_idx   <= 1'b1;
                                r_cnt        <= '0;
                                r_frame_done <= w_p_is_one;
                            end else begin
                                // Frame end with nothing to chain.
                                r_state <= ST_IDLE;
                                r_cnt   <= '0;
                                r_tx    <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt        <= w_cnt_inc;
                            r_frame_done <= (w_cnt_inc == w_p_last) && w_final_stop;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.Ready    = w_ready;
    assign o_tx_out     = r_tx;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_state      = r_state;

endmodule
